// File: rtl/if_fetch_pkg.sv
// Shared constants, state encodings and defaults for the instruction-fetch stage.
// The optional stall buffer is enabled with IF_FETCH_BUF_EN.
package if_fetch_pkg;

  localparam logic        enable_signal       = 1'b1;
  localparam int          inst_addr_bus_width = 32;
  localparam int          InstBus             = 32;
  localparam logic [31:0] zero_word           = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: controller inputs, instruction-memory handshake and if_id outputs.
// master is the fetch stage, slave is its environment (memory, ctrl, ID/EX, if_id).
interface if_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) ();

  logic              stall;
  logic              branch_flag_i;
  logic [ADDR_W-1:0] branch_target_i;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_valid;

  modport master (
    input  stall, branch_flag_i, branch_target_i, imem_ack, imem_rdata,
    output imem_req, imem_addr, if_pc, if_inst, if_valid
  );

  modport slave (
    output stall, branch_flag_i, branch_target_i, imem_ack, imem_rdata,
    input  imem_req, imem_addr, if_pc, if_inst, if_valid
  );

endinterface

// File: rtl/if_fetch_buf.sv
// One-entry holding buffer for an instruction returned while the pipeline is stalled.
// Flush wins over load, load wins over drain.
module if_fetch_buf #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              drain_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      inst_d  = inst_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack and drives the if_id register.
// Define IF_FETCH_BUF_EN to keep an instruction acked during stall instead of refetching it.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                ADDR_W   = inst_addr_bus_width,
  parameter int                INST_W   = InstBus,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic      clk,
  input  logic      rst,
  if_fetch_if.master bus
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [INST_W-1:0] if_inst_q, if_inst_d;
  logic              if_valid_q, if_valid_d;
  logic [ADDR_W-1:0] target_aligned;

  assign target_aligned = bus.branch_target_i & ~ADDR_W'(3);

`ifdef IF_FETCH_BUF_EN
  logic              buf_load, buf_drain, buf_valid;
  logic [ADDR_W-1:0] buf_pc;
  logic [INST_W-1:0] buf_inst;

  if_fetch_buf #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .drain_i (buf_drain),
    .flush_i (bus.branch_flag_i),
    .pc_i    (addr_q),
    .inst_i  (bus.imem_rdata),
    .valid_o (buf_valid),
    .pc_o    (buf_pc),
    .inst_o  (buf_inst)
  );
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
`ifdef IF_FETCH_BUF_EN
    buf_load   = 1'b0;
    buf_drain  = 1'b0;
`endif
    // Redirect beats everything but reset; a same-cycle ack is thrown away.
    if (bus.branch_flag_i) begin
      pc_d       = target_aligned;
      addr_d     = target_aligned;
      req_d      = 1'b1;
      state_d    = S_FETCH;
      if_valid_d = 1'b0;
      if_inst_d  = INST_W'(zero_word);
    end else begin
      case (state_q)
        S_IDLE: begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = S_FETCH;
        end
        S_FETCH: begin
          if (bus.imem_ack && !bus.stall) begin
            if_pc_d    = addr_q;
            if_inst_d  = bus.imem_rdata;
            if_valid_d = 1'b1;
            pc_d       = pc_q + ADDR_W'(4);
            addr_d     = pc_q + ADDR_W'(4);
          end else if (!bus.stall) begin
            if_inst_d  = INST_W'(zero_word);
            if_valid_d = 1'b0;
`ifdef IF_FETCH_BUF_EN
          end else if (bus.imem_ack) begin
            buf_load = 1'b1;
            req_d    = 1'b0;
            state_d  = S_HOLD;
`endif
          end
        end
`ifdef IF_FETCH_BUF_EN
        S_HOLD: begin
          if (!bus.stall) begin
            buf_drain  = 1'b1;
            if_pc_d    = buf_pc;
            if_inst_d  = buf_inst;
            if_valid_d = buf_valid;
            pc_d       = pc_q + ADDR_W'(4);
            addr_d     = pc_q + ADDR_W'(4);
            req_d      = 1'b1;
            state_d    = S_FETCH;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == enable_signal) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= '0;
      if_pc_q    <= '0;
      if_inst_q  <= INST_W'(zero_word);
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_inst   = if_inst_q;
  assign bus.if_valid  = if_valid_q;

endmodule
